// File: rtl/kd_tree_pkg.sv
// Shared kd-tree link definitions: bus widths, command codes, axis encodings
// and the node FSM state type. Imported by every node and the host controller.
package kd_tree_pkg;

    localparam int COMMAND_SIZE = 5;
    localparam int DATA_SIZE    = 24;

    localparam logic [COMMAND_SIZE-1:0] CMD_NOP                      = 5'h00;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL              = 5'h01;
    localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS      = 5'h02;
    localparam logic [COMMAND_SIZE-1:0] CMD_RECIEVE_CENTER           = 5'h03;
    localparam logic [COMMAND_SIZE-1:0] CMD_SWITCH_WITH_LEFT         = 5'h04;
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE         = 5'h05;
    localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'h07;
    localparam logic [COMMAND_SIZE-1:0] CMD_BUSY                     = 5'h08;
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING            = 5'h09;
    localparam logic [COMMAND_SIZE-1:0] CMD_DNE                      = 5'h10;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE                 = 5'h1e;
    localparam logic [COMMAND_SIZE-1:0] CMD_RST                      = 5'h1f;

    localparam logic [1:0] AXIS_R = 2'd0;
    localparam logic [1:0] AXIS_G = 2'd1;
    localparam logic [1:0] AXIS_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } node_state_t;

    // Encoding 3 is reserved: a configure request carrying it keeps the old axis.
    function automatic logic [1:0] next_axis(input logic [1:0] requested,
                                             input logic [1:0] current);
        logic [1:0] result;
        if (requested == 2'd3) begin
            result = current;
        end else begin
            result = requested;
        end
        return result;
    endfunction

    function automatic logic [DATA_SIZE-1:0] axis_word(input logic [1:0] axis);
        return {22'b0, axis};
    endfunction

endpackage

// File: rtl/kd_leaf_node_if.sv
// Command/data link between a kd-tree node and its parent (from_top downward,
// to_top upward).
interface kd_leaf_node_if;
    import kd_tree_pkg::*;

    logic [COMMAND_SIZE-1:0] command_from_top;
    logic [DATA_SIZE-1:0]    data_from_top;
    logic [COMMAND_SIZE-1:0] command_to_top;
    logic [DATA_SIZE-1:0]    data_to_top;

    modport master (
        output command_from_top,
        output data_from_top,
        input  command_to_top,
        input  data_to_top
    );

    modport slave (
        input  command_from_top,
        input  data_from_top,
        output command_to_top,
        output data_to_top
    );

endinterface

// File: rtl/kd_leaf_node.sv
// Terminal kd-tree responder: holds one RGB center and answers fill, axis,
// swap and sort commands with registered responses on the to_top channel.
module kd_leaf_node
    import kd_tree_pkg::*;
#(
    parameter int SORT_LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    kd_leaf_node_if.slave   bus
);

    localparam logic [3:0] BUSY_INIT = 4'(SORT_LATENCY - 1);

    logic [DATA_SIZE-1:0]    center_r;
    logic                    center_valid_r;
    logic [1:0]              axis_r;
    logic [3:0]              busy_cnt_r;
    node_state_t             state_r;
    logic [COMMAND_SIZE-1:0] cmd_out_r;
    logic [DATA_SIZE-1:0]    data_out_r;

    logic [COMMAND_SIZE-1:0] cmd_in_s;
    logic [DATA_SIZE-1:0]    data_in_s;
    logic [1:0]              axis_new_s;

    assign cmd_in_s   = bus.command_from_top;
    assign data_in_s  = bus.data_from_top;
    assign axis_new_s = next_axis(data_in_s[1:0], axis_r);

    assign bus.command_to_top = cmd_out_r;
    assign bus.data_to_top    = data_out_r;

    // Node FSM, center/axis storage, sort counter and registered responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            center_r       <= 24'h000000;
            center_valid_r <= 1'b0;
            axis_r         <= AXIS_R;
            busy_cnt_r     <= 4'd0;
            state_r        <= ST_IDLE;
            cmd_out_r      <= CMD_NOP;
            data_out_r     <= 24'h000000;
        end else begin
            case (state_r)
                ST_BUSY: begin
                    if (cmd_in_s == CMD_RST) begin
                        center_r       <= 24'h000000;
                        center_valid_r <= 1'b0;
                        axis_r         <= AXIS_R;
                        busy_cnt_r     <= 4'd0;
                        state_r        <= ST_IDLE;
                        cmd_out_r      <= CMD_RST_DONE;
                        data_out_r     <= 24'h000000;
                    end else if (busy_cnt_r != 4'd0) begin
                        busy_cnt_r <= busy_cnt_r - 4'd1;
                        cmd_out_r  <= CMD_BUSY;
                        data_out_r <= center_r;
                    end else begin
                        state_r    <= ST_DONE;
                        cmd_out_r  <= CMD_DNE;
                        data_out_r <= center_r;
                    end
                end

                // IDLE and DONE share command handling; only nop differs.
                ST_IDLE, ST_DONE: begin
                    case (cmd_in_s)
                        CMD_RST: begin
                            center_r       <= 24'h000000;
                            center_valid_r <= 1'b0;
                            axis_r         <= AXIS_R;
                            busy_cnt_r     <= 4'd0;
                            state_r        <= ST_IDLE;
                            cmd_out_r      <= CMD_RST_DONE;
                            data_out_r     <= 24'h000000;
                        end
                        CMD_CENTER_FILL: begin
                            state_r <= ST_IDLE;
                            if (!center_valid_r) begin
                                center_r       <= data_in_s;
                                center_valid_r <= 1'b1;
                                cmd_out_r      <= CMD_RECIEVE_CENTER;
                                data_out_r     <= data_in_s;
                            end else begin
                                cmd_out_r  <= CMD_CENTER_FILL_DONE;
                                data_out_r <= center_r;
                            end
                        end
                        CMD_CONFIGURE_SORT_AXIS: begin
                            state_r    <= ST_IDLE;
                            axis_r     <= axis_new_s;
                            cmd_out_r  <= CMD_CONFIGURE_SORT_AXIS_DONE;
                            data_out_r <= axis_word(axis_new_s);
                        end
                        CMD_SWITCH_WITH_LEFT: begin
                            state_r        <= ST_IDLE;
                            center_r       <= data_in_s;
                            center_valid_r <= 1'b1;
                            cmd_out_r      <= CMD_SWITCH_WITH_LEFT;
                            data_out_r     <= center_r;
                        end
                        CMD_START_SORTING: begin
                            if (center_valid_r) begin
                                state_r    <= ST_BUSY;
                                busy_cnt_r <= BUSY_INIT;
                                cmd_out_r  <= CMD_BUSY;
                                data_out_r <= center_r;
                            end else begin
                                state_r    <= ST_DONE;
                                cmd_out_r  <= CMD_DNE;
                                data_out_r <= 24'h000000;
                            end
                        end
                        default: begin
                            // nop and any undefined code
                            data_out_r <= center_r;
                            if (state_r == ST_DONE) begin
                                cmd_out_r <= CMD_DNE;
                            end else begin
                                cmd_out_r <= CMD_NOP;
                            end
                        end
                    endcase
                end

                default: begin
                    state_r    <= ST_IDLE;
                    busy_cnt_r <= 4'd0;
                    cmd_out_r  <= CMD_NOP;
                    data_out_r <= center_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kd_leaf_node.sv
// Directed bench for kd_leaf_node: reset, fill, axis, swap, sort, abort and
// asynchronous reset scenarios with hand-computed responses.
module tb_kd_leaf_node;
    import kd_tree_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    kd_leaf_node_if bus ();

    kd_leaf_node #(.SORT_LATENCY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [4:0] cmd, input logic [23:0] data);
        bus.command_from_top = cmd;
        bus.data_from_top    = data;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] exp_cmd,
                         input logic [23:0] exp_data);
        n_checks++;
        assert (bus.command_to_top === exp_cmd && bus.data_to_top === exp_data)
        else begin
            n_fail++;
            $error("FAIL %s: got cmd=%h data=%h, expected cmd=%h data=%h",
                   tag, bus.command_to_top, bus.data_to_top, exp_cmd, exp_data);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [4:0] exp_cmd);
        n_checks++;
        assert (bus.command_to_top === exp_cmd)
        else begin
            n_fail++;
            $error("FAIL %s: got cmd=%h, expected cmd=%h",
                   tag, bus.command_to_top, exp_cmd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.command_from_top = 5'h00;
        bus.data_from_top    = 24'h000000;

        // Reset held two cycles, then rst command
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", 5'h00, 24'h000000);
        reset = 1'b1;
        apply(5'h1f, 24'h123456); check("rst_cmd", 5'h1e, 24'h000000);
        apply(5'h02, 24'h000003); check("axis_reserved_after_rst", 5'h07, 24'h000000);

        // Fill: first capture, then repeated fill holds the old center
        apply(5'h01, 24'hA1B2C3); check("fill_first", 5'h03, 24'hA1B2C3);
        for (int i = 0; i < 3; i++) begin
            apply(5'h01, 24'h112233); check("fill_held", 5'h05, 24'hA1B2C3);
        end

        // Axis configuration
        apply(5'h02, 24'h000002); check("axis_b", 5'h07, 24'h000002);
        apply(5'h02, 24'h000003); check("axis_reserved", 5'h07, 24'h000002);
        apply(5'h02, 24'hFFFF01); check("axis_g", 5'h07, 24'h000001);

        // Switch returns the old center, next nop shows the new one
        apply(5'h04, 24'h0F0F0F); check("switch", 5'h04, 24'hA1B2C3);
        apply(5'h00, 24'h000000); check("nop_after_switch", 5'h00, 24'h0F0F0F);
        apply(5'h06, 24'hFFFFFF); check("undefined_06", 5'h00, 24'h0F0F0F);
        apply(5'h0a, 24'hFFFFFF); check("undefined_0a", 5'h00, 24'h0F0F0F);

        // Sort: exactly four busy cycles, fill during busy is ignored
        apply(5'h09, 24'h000000); check_cmd("busy_1", 5'h08);
        apply(5'h01, 24'h123456); check_cmd("busy_2", 5'h08);
        apply(5'h04, 24'h654321); check_cmd("busy_3", 5'h08);
        apply(5'h00, 24'h000000); check_cmd("busy_4", 5'h08);
        apply(5'h00, 24'h000000); check("dne", 5'h10, 24'h0F0F0F);
        apply(5'h00, 24'h000000); check("dne_held", 5'h10, 24'h0F0F0F);
        apply(5'h0a, 24'h000000); check("dne_undefined", 5'h10, 24'h0F0F0F);

        // Command from DONE processed as in IDLE, then back to IDLE
        apply(5'h04, 24'hABCDEF); check("switch_from_done", 5'h04, 24'h0F0F0F);
        apply(5'h00, 24'h000000); check("idle_after_done", 5'h00, 24'hABCDEF);

        // Empty center sort goes straight to dne with zero data
        apply(5'h1f, 24'h000000); check("rst_again", 5'h1e, 24'h000000);
        apply(5'h09, 24'h000000); check("empty_sort", 5'h10, 24'h000000);
        apply(5'h00, 24'h000000); check("empty_dne_held", 5'h10, 24'h000000);
        apply(5'h01, 24'h555555); check("fill_from_done", 5'h03, 24'h555555);
        apply(5'h00, 24'h000000); check("idle_after_fill", 5'h00, 24'h555555);

        // Abort a sort with rst
        apply(5'h09, 24'h000000); check_cmd("abort_busy_1", 5'h08);
        apply(5'h1f, 24'h000000); check("abort_rst", 5'h1e, 24'h000000);
        apply(5'h09, 24'h000000); check("abort_cleared_valid", 5'h10, 24'h000000);
        apply(5'h00, 24'h000000); check("abort_dne_held", 5'h10, 24'h000000);

        // Asynchronous reset mid-BUSY
        apply(5'h01, 24'h777777); check("fill_before_async", 5'h03, 24'h777777);
        apply(5'h09, 24'h000000); check_cmd("async_busy_1", 5'h08);
        apply(5'h00, 24'h000000); check_cmd("async_busy_2", 5'h08);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", 5'h00, 24'h000000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(5'h00, 24'h000000); check("after_async_idle", 5'h00, 24'h000000);
        apply(5'h09, 24'h000000); check("after_async_no_count", 5'h10, 24'h000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kd_leaf_node.md
Name: kd_leaf_node

Overview:
Terminal responder for the kd-tree command/data link. It answers the command stream a parent node or host drives downward, and replaces the constant "dne" tie-offs on unused child ports. It holds one 24-bit RGB center and responds to reset, center fill, axis configuration, switch-with-parent and sort commands. All responses are registered and go back up the tree's to_top channel.

Parameters:
COMMAND_SIZE, 5, width of command buses
DATA_SIZE, 24, width of data buses (packed R[23:16] G[15:8] B[7:0])
SORT_LATENCY, 4, cycles the node reports busy after start_sorting (1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low (0 = reset asserted)
command_from_top  in  COMMAND_SIZE  command from parent
data_from_top  in  DATA_SIZE  data from parent
command_to_top  out  COMMAND_SIZE  registered response to parent
data_to_top  out  DATA_SIZE  registered data to parent

Behaviour:
- Command codes: nop 0x00, center_fill 0x01, configure_sort_axis 0x02, recieve_center 0x03, switch_with_left 0x04, center_fill_done 0x05, configure_sort_axis_done 0x07, busy 0x08, start_sorting 0x09, dne 0x10, rst_done 0x1e, rst 0x1f.
- Internal state: center[23:0], center_valid, axis[1:0], busy_cnt[3:0], FSM {IDLE, BUSY, DONE}.
- Reset (reset==0, async): center=0, center_valid=0, axis=0, busy_cnt=0, FSM=IDLE, command_to_top=nop, data_to_top=0.
- Latency: a command sampled at posedge N produces its response at posedge N; the response is visible to the parent from N until N+1. The parent samples it on the negedge after N.
- rst: clears center, center_valid, axis and busy_cnt; FSM=IDLE; response rst_done; data 0. Valid in any state and aborts BUSY.
- center_fill with center_valid=0: center<=data_from_top, center_valid<=1, response recieve_center, data_to_top<=data_from_top.
- center_fill with center_valid=1: no capture; response center_fill_done; data_to_top=center. Held for every cycle the command persists.
- configure_sort_axis: axis<=data_from_top[1:0] when the value is 0..2 (R, G, B); value 3 leaves axis unchanged. Response configure_sort_axis_done in both cases; data_to_top={22'b0,axis_new}.
- switch_with_left: data_to_top<=center (old value), center<=data_from_top, center_valid<=1; response switch_with_left. A swap in the same cycle returns the old value, not the incoming one.
- start_sorting in IDLE or DONE:
  - center_valid=1: FSM=BUSY, busy_cnt=SORT_LATENCY-1, response busy.
  - center_valid=0: FSM=DONE, response dne, data 0.
- BUSY:
  - Any command other than rst is ignored. Response is busy while busy_cnt!=0, decrementing each cycle.
  - When busy_cnt==0, FSM=DONE, response dne, data_to_top=center.
  - Total busy cycles = SORT_LATENCY.
- DONE: response dne and data_to_top=center, held across nop. Any non-nop command is processed as in IDLE; FSM returns to IDLE unless the command is start_sorting.
- IDLE with nop: response nop, data_to_top=center.
- Undefined codes (0x06, 0x0a and others): treated as nop.
- Reset deasserting mid-BUSY: no residual count; the node starts in IDLE.
- data_to_top always carries a full 24-bit value with no truncation. axis only affects the response data in this block.

Decomposition:
- kd_tree_pkg: COMMAND_SIZE, DATA_SIZE, all command code localparams, axis encodings (AXIS_R=0, AXIS_G=1, AXIS_B=2). The node and the host controller import the same package.
- No sub-module. The single FSM, the counter and the registers stay in kd_leaf_node.

Test Plan:
- Reset then rst: hold reset=0 2 cycles -> outputs nop/0. Release, drive rst -> command_to_top=0x1e, data 0.
- Fill: center_fill with data 0xA1B2C3 -> recieve_center (0x03), data 0xA1B2C3. Hold center_fill with data 0x112233 -> center_fill_done (0x05), data stays 0xA1B2C3 every cycle.
- Axis: configure_sort_axis data 2 -> 0x07, data 0x000002. Then data 3 -> 0x07, data 0x000002 (unchanged).
- Switch: center 0xA1B2C3, switch_with_left data 0x0F0F0F -> response 0x04, data 0xA1B2C3. Then nop -> nop, data 0x0F0F0F.
- Sort, SORT_LATENCY=4: start_sorting then nop -> busy (0x08) for exactly 4 cycles, then dne (0x10) with data=center held across nops. Empty center -> dne next cycle, data 0.
- Abort: start_sorting, then rst on 2nd busy cycle -> rst_done, center_valid=0. Async reset=0 mid-BUSY -> outputs nop/0 immediately, before the next clock edge.
